// File: rtl/dsu_pkg.sv
// Shared types and per-layer configuration for the DSU layer sequencer.
// Layer table is indexed by the 4-bit layer number.
package dsu_pkg;

  typedef struct packed {
    logic [7:0] input_size;
    logic [7:0] output_size;
    logic [7:0] input_channel;
    logic [7:0] output_channel;
  } layer_cfg_t;

  localparam layer_cfg_t CFG_A = '{8'd32, 8'd32, 8'd4, 8'd8};
  localparam layer_cfg_t CFG_B = '{8'd32, 8'd16, 8'd8, 8'd32};
  localparam layer_cfg_t CFG_C = '{8'd16, 8'd8, 8'd32, 8'd64};
  localparam layer_cfg_t CFG_Z = '{8'd0, 8'd0, 8'd0, 8'd0};

  localparam layer_cfg_t LAYER_CFG [0:15] = '{
    CFG_A, CFG_A, CFG_A, CFG_A,
    CFG_B, CFG_B, CFG_B, CFG_B,
    CFG_C, CFG_C, CFG_C, CFG_C,
    CFG_Z, CFG_Z, CFG_Z, CFG_Z
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_RUN,
    S_NEXT,
    S_FINISH
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// No-progress watchdog: counts unstalled cycles, clears on progress.
// timeout fires in the cycle whose increment would reach the limit.
module seq_watchdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        hold,
  input  logic [15:0] limit,
  output logic        timeout
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign timeout = !clear && !hold && (cnt_q == limit - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsu_layer_sequencer.sv
// Layer-level controller for the depthwise-separable unit.
// Walks layers, pulses init, gates enables and watches for stalls.
module dsu_layer_sequencer
  import dsu_pkg::*;
#(
  parameter int NUM_LAYERS = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] first_layer,
  input  logic       abort,
  input  logic       stall,
  input  logic       depth_layer_done,
  input  logic       point_done,
  input  logic       first_cycle,
  input  logic       point11_done,
  output logic [3:0] layer,
  output logic [7:0] input_size,
  output logic [7:0] output_size,
  output logic [7:0] input_channel,
  output logic [7:0] output_channel,
  output logic       init,
  output logic       en,
  output logic       depth_en,
  output logic       point_en,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [3:0]  LAST  = 4'(NUM_LAYERS - 1);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  seq_state_t state_q, state_d;
  layer_cfg_t cfg_q, cfg_d;
  logic [3:0] layer_q, layer_d;
  logic       dl_q, dl_d;
  logic       pd_q, pd_d;
  logic       error_q, error_d;
  logic       init_q, init_d;
  logic       run_q, run_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic progress;
  logic complete;
  logic wd_clear;
  logic wd_timeout;

  assign progress = first_cycle | point11_done
                  | depth_layer_done | point_done;
  assign complete = (dl_q | depth_layer_done)
                  & (pd_q | point_done);
  assign wd_clear = (state_q != S_RUN) | progress;

  seq_watchdog u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .hold    (stall),
    .limit   (LIMIT),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cfg_d   = cfg_q;
    dl_d    = dl_q;
    pd_d    = pd_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          layer_d = first_layer;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        cfg_d   = LAYER_CFG[layer_q];
        dl_d    = 1'b0;
        pd_d    = 1'b0;
        state_d = S_INIT;
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        dl_d = dl_q | depth_layer_done;
        pd_d = pd_q | point_done;
        if (complete) begin
          state_d = S_NEXT;
        end else if (wd_timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        if (layer_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          layer_d = layer_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // abort wins over start and timeout; it never touches layer or error
    if (abort) begin
      state_d = S_IDLE;
      layer_d = layer_q;
      error_d = error_q;
    end
    init_d = (state_d == S_INIT);
    run_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cfg_q   <= '0;
      dl_q    <= 1'b0;
      pd_q    <= 1'b0;
      error_q <= 1'b0;
      init_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cfg_q   <= cfg_d;
      dl_q    <= dl_d;
      pd_q    <= pd_d;
      error_q <= error_d;
      init_q  <= init_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign layer          = layer_q;
  assign input_size     = cfg_q.input_size;
  assign output_size    = cfg_q.output_size;
  assign input_channel  = cfg_q.input_channel;
  assign output_channel = cfg_q.output_channel;
  assign init           = init_q;
  assign en             = init_q | (run_q & ~stall);
  assign depth_en       = init_q | run_q;
  assign point_en       = init_q | run_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_dsu_layer_sequencer.sv
// Randomized scoreboard bench for dsu_layer_sequencer.
// Driver plans a timeline from the layer rules; monitor compares.
module tb_dsu_layer_sequencer;

  localparam int NL = 12;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst, start, abort, stall;
  logic       dld, pdn, fc, p11;
  logic [3:0] first_layer;
  logic [3:0] layer;
  logic [7:0] isz, osz, ich, och;
  logic       init, en, den, pen, busy, done, error;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  dsu_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .first_layer      (first_layer),
    .abort            (abort),
    .stall            (stall),
    .depth_layer_done (dld),
    .point_done       (pdn),
    .first_cycle      (fc),
    .point11_done     (p11),
    .layer            (layer),
    .input_size       (isz),
    .output_size      (osz),
    .input_channel    (ich),
    .output_channel   (och),
    .init             (init),
    .en               (en),
    .depth_en         (den),
    .point_en         (pen),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  typedef struct {
    int cyc;
    int kind;
    int layer;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        en;
    logic        den;
    logic        busy;
    logic        err;
    int          layer;
    logic [31:0] cfg;
  } smp_t;

  ev_t  evq[$];
  smp_t smq[$];

  function automatic logic [31:0] exp_cfg(input int l);
    if (l < 4)  return {8'd32, 8'd32, 8'd4, 8'd8};
    if (l < 8)  return {8'd32, 8'd16, 8'd8, 8'd32};
    if (l < 12) return {8'd16, 8'd8, 8'd32, 8'd64};
    return 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input int k, input int l);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.layer = l;
    evq.push_back(e);
  endtask

  task automatic push_smp(input int c, input logic e_, input logic d_,
                          input logic b_, input logic er, input int l,
                          input logic [31:0] cf);
    smp_t s;
    s.cyc = c;
    s.en = e_;
    s.den = d_;
    s.busy = b_;
    s.err = er;
    s.layer = l;
    s.cfg = cf;
    smq.push_back(s);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind %0d cycle %0d: got event expected none",
               kind, cyc);
    end else begin
      e = evq.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_layer", {28'd0, layer}, e.layer);
    end
  endtask

  // monitor: events (init, done, error rise) and per-cycle samples
  initial begin
    logic err_prev;
    smp_t s;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (init === 1'b1) check_ev(0);
      if (done === 1'b1) check_ev(1);
      if (error === 1'b1 && !err_prev) check_ev(2);
      err_prev = (error === 1'b1);
      while (smq.size() > 0 && smq[0].cyc <= cyc) begin
        s = smq.pop_front();
        if (s.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL sample_missed: got cycle %0d expected cycle %0d",
                   cyc, s.cyc);
        end else begin
          chk("en", en, s.en);
          chk("depth_en", den, s.den);
          chk("point_en", pen, s.den);
          chk("busy", busy, s.busy);
          chk("error", error, s.err);
          chk("layer", {28'd0, layer}, s.layer);
          chk("cfg", {isz, osz, ich, och}, s.cfg);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    dld = 1'b0;
    pdn = 1'b0;
    fc = 1'b0;
    p11 = 1'b0;
  endtask

  // noise outside RUN: starts and completion pulses must be ignored
  task automatic junk();
    start = 1'($urandom % 2);
    first_layer = 4'($urandom);
    abort = 1'b0;
    stall = 1'($urandom % 2);
    dld = ($urandom % 3 == 0);
    pdn = ($urandom % 3 == 0);
    fc = ($urandom % 3 == 0);
    p11 = ($urandom % 3 == 0);
  endtask

  // mode: 0 random, 1 pulses at 100/140, 2 same-cycle pulses,
  // 3 timeout with 20-cycle stall, 4 abort in INIT, 5 rst at layer 2
  task automatic run(input int fl, input int mode);
    int k, L, I, C, a, b, w, j;
    logic s, di, pi, f, p, dl, pd, dir;
    clear_in();
    start = 1'b1;
    first_layer = 4'(fl);
    k = cyc;
    L = fl;
    I = k + 2;
    push_ev(I, 0, L);
    step();
    start = 1'b0;
    forever begin
      while (cyc <= I) begin
        junk();
        if (cyc == I) push_smp(I, 1'b1, 1'b1, 1'b1, 1'b0, L, exp_cfg(L));
        if (mode == 4 && cyc == I) begin
          clear_in();
          abort = 1'b1;
          step();
          abort = 1'b0;
          push_smp(cyc, 1'b0, 1'b0, 1'b0, 1'b0, L, exp_cfg(L));
          return;
        end
        step();
      end
      clear_in();
      dl = 1'b0;
      pd = 1'b0;
      w = 0;
      dir = (mode == 1 || mode == 3) && L == fl;
      if (mode == 1 && L == fl) begin
        a = 100;
        b = 140;
      end else if (mode == 2) begin
        a = $urandom_range(1, 40);
        b = a;
      end else if (mode == 3 && L == fl) begin
        a = -1;
        b = -1;
      end else if (mode == 5 && L == 2) begin
        a = $urandom_range(6, 40);
        b = $urandom_range(6, 40);
      end else begin
        a = $urandom_range(1, 45);
        b = $urandom_range(1, 45);
      end
      forever begin
        j = cyc - I;
        if (mode == 5 && L == 2 && j == 5) begin
          clear_in();
          rst = 1'b1;
          step();
          rst = 1'b0;
          push_smp(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
          return;
        end
        if (mode == 3 && L == fl) s = (j >= 10 && j < 30);
        else s = ($urandom % 4 == 0);
        di = (j == a);
        pi = (j == b);
        f = dir ? (mode == 1 && j % 30 == 0) : ($urandom % 6 == 0);
        p = dir ? 1'b0 : ($urandom % 12 == 0);
        stall = s;
        dld = di;
        pdn = pi;
        fc = f;
        p11 = p;
        push_smp(cyc, !s, 1'b1, 1'b1, 1'b0, L, exp_cfg(L));
        if (di || pi || f || p) w = 0;
        else if (!s) w++;
        dl = dl | di;
        pd = pd | pi;
        step();
        if (dl && pd) break;
        if (w == TO) begin
          clear_in();
          push_ev(cyc, 2, L);
          push_smp(cyc, 1'b0, 1'b0, 1'b0, 1'b1, L, exp_cfg(L));
          return;
        end
      end
      C = cyc - 1;
      push_smp(C + 1, 1'b0, 1'b0, 1'b1, 1'b0, L, exp_cfg(L));
      if (L == NL - 1) begin
        push_ev(C + 2, 1, L);
        push_smp(C + 2, 1'b0, 1'b0, 1'b1, 1'b0, L, exp_cfg(L));
        push_smp(C + 3, 1'b0, 1'b0, 1'b0, 1'b0, L, exp_cfg(L));
        junk();
        step();
        junk();
        step();
        clear_in();
        return;
      end
      push_smp(C + 2, 1'b0, 1'b0, 1'b1, 1'b0, L + 1, exp_cfg(L));
      L++;
      I = C + 3;
      push_ev(I, 0, L);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    first_layer = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    push_smp(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
    step();
    step();
    run(10, 2);
    run(0, 1);
    run(4, 0);
    run(3, 3);
    run(5, 0);
    run(1, 4);
    run(0, 5);
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom % NL), 0);
      repeat (int'($urandom % 3)) step();
    end
    repeat (10) step();
    chk("events_drained", evq.size(), 32'd0);
    chk("samples_drained", smq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
